irq_controller: RTL and testbench

- Memory-mapped interrupt controller. It is the responder on the CPU data bus (memaddr/memread/memwrite/be/writedata/readdata) and the source of the CPU's active-low nIRQ input.
- Collects up to 16 external interrupt sources.
- Latches them as edge- or level-triggered pending bits, masks them, and resolves priority.
- Lets software enable, clear, set and claim interrupts through word registers.

---
 rtl/irq_controller.sv | 180 ++++++++++++++++++
 tb/tb_irq_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller with a 32-byte register window on the CPU data bus.
// Latches up to 16 sources as edge- or level-triggered pending bits, masks them,
// resolves lowest-index-first priority and drives the active-low nIRQ line.
// Optional feature macro: IRQ_LATENCY_CNT_EN (adds the LATCNT register at 0x1C).
module irq_controller #(
  parameter int unsigned NUM_SRC     = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        memaddr,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [3:0]         be,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               nIRQ
);

  localparam int unsigned ID_W = 4;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_RAW    = 3'd1;
  localparam logic [2:0] REG_ENABLE = 3'd2;
  localparam logic [2:0] REG_CLEAR  = 3'd3;
  localparam logic [2:0] REG_CLAIM  = 3'd4;
  localparam logic [2:0] REG_MODE   = 3'd5;
  localparam logic [2:0] REG_SWSET  = 3'd6;
  localparam logic [2:0] REG_LATCNT = 3'd7;

  // State
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
  logic [NUM_SRC-1:0] s_d_q, s_d_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic               nirq_q, nirq_d;

  // Decode and derived values
  logic               hit;
  logic [2:0]         reg_idx;
  logic               wr_en;
  logic               rd_en;
  logic [15:0]        lane_mask16;
  logic [NUM_SRC-1:0] lane_mask;
  logic [NUM_SRC-1:0] wr_bits;
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] status;
  logic [ID_W-1:0]    claim_id;
  logic               claim_valid;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] clear_bits;
  logic [NUM_SRC-1:0] set_bits;

  // Inputs that carry no state (upper lanes, byte offset) are folded here.
  logic unused_bits;
  assign unused_bits = ^{writedata[31:16], be[3:2], memaddr[1:0]};

  // Address decode and byte-lane write data
  always_comb begin
    hit         = (memaddr[31:5] == BASE_ADDR[31:5]);
    reg_idx     = memaddr[4:2];
    wr_en       = hit && memwrite;
    rd_en       = hit && memread;
    lane_mask16 = {{8{be[1]}}, {8{be[0]}}};
    lane_mask   = NUM_SRC'(lane_mask16);
    wr_bits     = NUM_SRC'(writedata[15:0] & lane_mask16);
  end

  // Masked status and lowest-index priority resolution
  always_comb begin
    s           = sync_q[SYNC_STAGES-1];
    status      = pending_q & enable_q;
    claim_valid = |status;
    claim_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (status[i]) claim_id = ID_W'(i);
    end
  end

  // Synchronizer chain: stage 0 samples the raw asynchronous lines
  always_comb begin
    sync_d[0] = irq_src;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Next-state for pending, enable, mode and the interrupt line
  always_comb begin
    s_d_d      = s;
    enable_d   = enable_q;
    mode_d     = mode_q;
    clear_bits = '0;
    claim_clr  = '0;
    set_bits   = (mode_q & s & ~s_d_q) | (~mode_q & s);

    if (wr_en) begin
      case (reg_idx)
        REG_ENABLE: enable_d   = (enable_q & ~lane_mask) | wr_bits;
        REG_MODE:   mode_d     = (mode_q & ~lane_mask) | wr_bits;
        REG_CLEAR:  clear_bits = wr_bits;
        REG_SWSET:  set_bits   = set_bits | wr_bits;
        default:    ;
      endcase
    end

    if (rd_en && (reg_idx == REG_CLAIM) && claim_valid) begin
      claim_clr = NUM_SRC'(1) << claim_id;
    end

    // A set event in the same cycle always wins over clear/claim.
    pending_d = (pending_q & ~(clear_bits | claim_clr)) | set_bits;
    nirq_d    = ~|status;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      s_d_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      nirq_q    <= 1'b1;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      s_d_q     <= s_d_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      nirq_q    <= nirq_d;
    end
  end

  assign nIRQ = nirq_q;

`ifdef IRQ_LATENCY_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Cycles spent with nIRQ asserted; saturating, software clear wins
  always_comb begin
    cnt_d = cnt_q;
    if (!nirq_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    if (wr_en && (reg_idx == REG_LATCNT) && (be[0] || be[1])) cnt_d = '0;
  end

  // Latency counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // Combinational read mux; zero when not selected so responders can be OR-ed
  always_comb begin
    readdata = '0;
    if (rd_en) begin
      case (reg_idx)
        REG_STATUS: readdata = 32'(status);
        REG_RAW:    readdata = 32'(pending_q);
        REG_ENABLE: readdata = 32'(enable_q);
        REG_CLAIM:  readdata = {claim_valid, 27'b0, claim_id};
        REG_MODE:   readdata = 32'(mode_q);
`ifdef IRQ_LATENCY_CNT_EN
        REG_LATCNT: readdata = {16'b0, cnt_q};
`endif
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (NUM_SRC=8, default base).
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] memaddr;
  logic        memread;
  logic        memwrite;
  logic [3:0]  be;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  irq_src;
  logic        nirq;

  int n_checks = 0;
  int n_errors = 0;

  irq_controller #(
    .NUM_SRC    (8),
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .memaddr  (memaddr),
    .memread  (memread),
    .memwrite (memwrite),
    .be       (be),
    .writedata(writedata),
    .readdata (readdata),
    .irq_src  (irq_src),
    .nIRQ     (nirq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the store commits on the following posedge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] b);
    memaddr   = addr;
    writedata = d;
    be        = b;
    memwrite  = 1'b1;
    @(negedge clk);
    memwrite  = 1'b0;
    be        = 4'b0;
    writedata = '0;
  endtask

  // Called at a negedge; checks the combinational data, then lets one edge pass.
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    memaddr = addr;
    memread = 1'b1;
    #1;
    chk(tag, readdata, exp);
    @(negedge clk);
    memread = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; memaddr = '0; memread = 1'b0; memwrite = 1'b0;
    be = '0; writedata = '0; irq_src = '0;
    repeat (3) @(negedge clk);
    chk("reset_nirq", 32'(nirq), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Post-reset register values
    rd("rst_status", BASE + 32'h00, 32'h0);
    rd("rst_raw",    BASE + 32'h04, 32'h0);
    rd("rst_enable", BASE + 32'h08, 32'h0);
    rd("rst_mode",   BASE + 32'h14, 32'h0);
    rd("rst_claim",  BASE + 32'h10, 32'h0);

    // Edge source on bit 2: pending after 3 edges, nIRQ after 4
    wr(BASE + 32'h14, 32'h04, 4'b1111);
    wr(BASE + 32'h08, 32'h04, 4'b1111);
    irq_src = 8'h04;
    @(negedge clk);
    irq_src = 8'h00;
    @(negedge clk);
    rd("edge_raw_e2", BASE + 32'h04, 32'h0);
    chk("edge_nirq_e3", 32'(nirq), 32'd1);
    rd("edge_raw_e3", BASE + 32'h04, 32'h04);
    chk("edge_nirq_e4", 32'(nirq), 32'd0);
    rd("edge_claim", BASE + 32'h10, 32'h80000002);
    chk("edge_nirq_claim_edge", 32'(nirq), 32'd0);
    @(negedge clk);
    chk("edge_nirq_released", 32'(nirq), 32'd1);
    rd("edge_raw_cleared", BASE + 32'h04, 32'h0);

    // Level mode, priority and masking
    wr(BASE + 32'h14, 32'h00, 4'b1111);
    wr(BASE + 32'h08, 32'h08, 4'b1111);
    irq_src = 8'h0A;
    repeat (3) @(negedge clk);
    rd("lvl_status", BASE + 32'h00, 32'h08);
    rd("lvl_claim3", BASE + 32'h10, 32'h80000003);
    rd("lvl_raw_after_claim", BASE + 32'h04, 32'h0A);
    wr(BASE + 32'h08, 32'h0A, 4'b1111);
    rd("lvl_claim1", BASE + 32'h10, 32'h80000001);
    wr(BASE + 32'h0C, 32'h02, 4'b0001);
    rd("lvl_clear_held", BASE + 32'h04, 32'h0A);
    rd("clear_reads0", BASE + 32'h0C, 32'h0);
    chk("lvl_nirq", 32'(nirq), 32'd0);
    irq_src = 8'h00;
    repeat (3) @(negedge clk);
    rd("lvl_sticky", BASE + 32'h04, 32'h0A);
    wr(BASE + 32'h0C, 32'hFF, 4'b0001);
    rd("lvl_cleared", BASE + 32'h04, 32'h0);
    chk("lvl_nirq_release", 32'(nirq), 32'd1);

    // Byte lanes and address decode
    wr(BASE + 32'h08, 32'h0, 4'b1111);
    wr(BASE + 32'h08, 32'hFFFFFFFF, 4'b0010);
    rd("lane1_only", BASE + 32'h08, 32'h0);
    wr(BASE + 32'h08, 32'hFFFFFFFF, 4'b0001);
    rd("lane0", BASE + 32'h08, 32'hFF);
    wr(BASE + 32'h28, 32'h0, 4'b1111);
    rd("nohit_read", BASE + 32'h28, 32'h0);
    rd("nohit_nowrite", BASE + 32'h08, 32'hFF);
    wr(BASE + 32'h08, 32'h0, 4'b1111);

    // Edge event and CLEAR land on the same edge: set wins
    wr(BASE + 32'h14, 32'h20, 4'b0001);
    irq_src = 8'h20;
    @(negedge clk);
    irq_src = 8'h00;
    @(negedge clk);
    wr(BASE + 32'h0C, 32'h20, 4'b0001);
    rd("set_beats_clear", BASE + 32'h04, 32'h20);
    wr(BASE + 32'h18, 32'h80, 4'b0001);
    rd("swset", BASE + 32'h04, 32'hA0);
    rd("swset_reads0", BASE + 32'h18, 32'h0);
    rd("status_masked", BASE + 32'h00, 32'h0);
    rd("claim_none", BASE + 32'h10, 32'h0);

    // Reset asserted mid-run
    wr(BASE + 32'h08, 32'h80, 4'b0001);
    @(negedge clk);
    chk("pre_reset_nirq", 32'(nirq), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_nirq", 32'(nirq), 32'd1);
    rd("midrst_status", BASE + 32'h00, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rd("midrst_raw",    BASE + 32'h04, 32'h0);
    rd("midrst_enable", BASE + 32'h08, 32'h0);
    rd("midrst_mode",   BASE + 32'h14, 32'h0);
    rd("midrst_claim",  BASE + 32'h10, 32'h0);

`ifdef IRQ_LATENCY_CNT_EN
    wr(BASE + 32'h08, 32'h01, 4'b0001);
    wr(BASE + 32'h18, 32'h01, 4'b0001);
    @(negedge clk);
    chk("lat_nirq", 32'(nirq), 32'd0);
    wr(BASE + 32'h1C, 32'h0, 4'b0001);
    repeat (100) @(negedge clk);
    rd("latcnt_100", BASE + 32'h1C, 32'd100);
    wr(BASE + 32'h1C, 32'h0, 4'b0010);
    rd("latcnt_clr", BASE + 32'h1C, 32'd0);
    repeat (70000) @(negedge clk);
    rd("latcnt_sat", BASE + 32'h1C, 32'h0000FFFF);
`else
    wr(BASE + 32'h1C, 32'hFFFF, 4'b1111);
    rd("reg1c_absent", BASE + 32'h1C, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
